async_fifo_rd_ctrl: RTL
=======================

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter W_ADDR, default 4, FIFO address width; depth = 2**W_ADDR.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth; legal range 2..4.
REQ-003 SHALL use one clock and a synchronous active-high reset:
  clk  input  1  read-domain clock; all state on rising edge
  rst  input  1  synchronous, active-high reset
REQ-004 SHALL have data ports:
  wptr_gray_async  input   W_ADDR+1  write pointer, Gray-coded, from write domain (asynchronous)
  ren              input   1         consumer pop request
  rptr_gray        output  W_ADDR+1  registered Gray read pointer, to write domain
  mem_raddr        output  W_ADDR    RAM address of current head entry
  empty            output  1         no entry available
  level            output  W_ADDR+1  entries available (synchronised view)
  pop              output  1         pop accepted this cycle
  err_underflow    output  1         one-cycle pulse: ren while empty

Function
REQ-005 SHALL pass wptr_gray_async through SYNC_STAGES flop stages, all bits in parallel, with no logic before the first stage.
REQ-006 SHALL convert the final synchronised pointer to binary (wptr_bin): MSB unchanged; each lower bit = its Gray bit XOR the next-higher binary bit.
REQ-007 SHALL hold read pointer rptr_bin (W_ADDR+1 bits), registered.
REQ-008 SHALL register rptr_gray as the Gray encoding of the next rptr_bin value (bin XOR bin>>1), so it changes at most one bit per cycle and is glitch-free.
REQ-009 SHALL drive empty = (rptr_gray == synchronised write pointer), combinational from registers only.
REQ-010 SHALL drive level = (wptr_bin - rptr_bin) mod 2**(W_ADDR+1).
REQ-011 SHALL drive pop = ren AND NOT empty; on pop, rptr_bin increments by 1 at the next edge.
REQ-012 SHALL ignore ren while empty: pointer unchanged, err_underflow = 1 in that cycle (combinational pulse); otherwise err_underflow = 0.
REQ-013 SHALL drive mem_raddr = rptr_bin[W_ADDR-1:0]; the head entry is valid whenever empty = 0.
REQ-014 SHALL wrap rptr_bin from 2**(W_ADDR+1)-1 to 0; level and empty SHALL remain correct across the wrap.
REQ-015 SHALL make a write-pointer change visible on empty/level exactly SYNC_STAGES clk edges after it is stable at the input.
REQ-016 SHALL allow back-to-back pops every cycle while empty = 0, with no bubble.
REQ-017 SHALL NOT flag overflow; level > 2**W_ADDR is a write-side protocol error and is reported raw.

Reset
REQ-018 SHALL, on a clk edge with rst = 1, clear all synchroniser stages, rptr_bin and rptr_gray to 0; rst takes priority over pop.
REQ-019 SHALL produce these outputs while in reset and on the first cycle after it: empty = 1, level = 0, mem_raddr = 0, pop = 0, err_underflow = ren.
REQ-020 SHALL, when reset is asserted mid-operation, abandon unread entries; the write side is reset by the same system reset.

Structure
REQ-021 SHALL take the Gray encode and Gray decode functions, and the pointer-width rule (W_ADDR+1), from a shared CDC package used by the write-side controller.
REQ-022 SHALL instantiate one sub-module, cdc_sync_bus (parameterised width and stage count), for the synchroniser; all other logic is inline.

Verification
REQ-023 SHALL cover the following directed scenarios, all with W_ADDR = 2 and SYNC_STAGES = 2:
  - Reset held 3 cycles with ren = 1 -> empty = 1, level = 0, rptr_gray = 000, err_underflow = 1, pop = 0.
  - wptr_gray_async set to 010 (binary 3) -> empty stays 1 after the 1st edge; after the 2nd edge empty = 0, level = 3.
  - Then ren held 3 cycles -> mem_raddr 0,1,2; rptr_gray 001, 011, 010; level 2, 1, 0; empty = 1 after the 3rd pop.
  - ren = 1 while empty -> err_underflow = 1 for that cycle only; rptr_gray unchanged.
  - Wrap: rptr_bin = 7 (gray 100), wptr = 1 (gray 001) -> level = 2; one pop -> rptr_gray = 000, mem_raddr = 0, level = 1.
  - rst pulsed for 1 cycle while level = 2 and ren = 1 -> at the next edge rptr_gray = 000 and empty = 1; no pop issued in the reset cycle.

Source files
------------

// File: rtl/async_fifo_rd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl_pkg
// Shared CDC helpers for the asynchronous FIFO pointer logic, used by both the
// read-side and write-side controllers so that both ends agree on pointer width
// and Gray coding.
//   cdc_ptr_width(w_addr) : pointer width for a FIFO of 2**w_addr entries
//   cdc_bin2gray(b)       : binary -> Gray (b ^ b>>1)
//   cdc_gray2bin(g)       : Gray -> binary (prefix XOR from the MSB down)
// Both converters work on a zero-extended CDC_MAX_W word, so any pointer width
// up to CDC_MAX_W is handled by casting in and out at the call site.
// -----------------------------------------------------------------------------
package async_fifo_rd_ctrl_pkg;

   localparam int CDC_MAX_W = 32;

   typedef logic [CDC_MAX_W-1:0] cdc_word_t;

   // One extra bit beyond the address distinguishes full from empty.
   function automatic int cdc_ptr_width(input int w_addr);
      return w_addr + 1;
   endfunction

   function automatic cdc_word_t cdc_bin2gray(input cdc_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Binary bit i is the XOR of all Gray bits at or above i; the zero
   // extension above the real pointer width leaves the result unaffected.
   function automatic cdc_word_t cdc_gray2bin(input cdc_word_t g);
      cdc_word_t b;
      for (int i = 0; i < CDC_MAX_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl_if
// Bundle between the read-side FIFO controller and its environment.
//   wptr_gray_async : Gray write pointer from the write clock domain
//   ren             : consumer pop request
//   rptr_gray       : registered Gray read pointer, to the write domain
//   mem_raddr       : RAM address of the current head entry
//   empty           : no entry available
//   level           : entries available (synchronised view)
//   pop             : pop accepted this cycle
//   err_underflow   : ren while empty
// Modports: master = environment (write side / consumer), slave = controller.
// -----------------------------------------------------------------------------
interface async_fifo_rd_ctrl_if
   import async_fifo_rd_ctrl_pkg::*;
#(
   parameter int W_ADDR = 4
);
   localparam int PTR_W = cdc_ptr_width(W_ADDR);

   logic [PTR_W-1:0]  wptr_gray_async;
   logic              ren;
   logic [PTR_W-1:0]  rptr_gray;
   logic [W_ADDR-1:0] mem_raddr;
   logic              empty;
   logic [PTR_W-1:0]  level;
   logic              pop;
   logic              err_underflow;

   modport master (
      output wptr_gray_async, ren,
      input  rptr_gray, mem_raddr, empty, level, pop, err_underflow
   );

   modport slave (
      input  wptr_gray_async, ren,
      output rptr_gray, mem_raddr, empty, level, pop, err_underflow
   );
endinterface

// File: rtl/async_fifo_rd_ctrl_cdc_sync_bus.sv
// -----------------------------------------------------------------------------
// cdc_sync_bus
// Multi-flop synchroniser for a Gray-coded bus. Every bit passes through STAGES
// flops in parallel with nothing in front of the first stage, so the only
// metastability exposure is the first flop. STAGES should be 2..4.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input bus
//   q   : synchronised output (last stage)
// -----------------------------------------------------------------------------
module cdc_sync_bus #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // NOTE: the stage array is a chain of flops, not a RAM, so resetting every
   // element is cheap and legal; a true memory array would be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value, giving a true shift rather than a
         // single-cycle pass-through.
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl
// Read-side controller of an asynchronous FIFO. Synchronises the Gray write
// pointer into the read domain, keeps the binary and Gray read pointers, and
// derives empty/level/pop/underflow for the consumer.
//   clk : read-domain clock
//   rst : synchronous active-high reset
//   bus : async_fifo_rd_ctrl_if.slave (see interface header for signals)
// Parameters: W_ADDR (depth = 2**W_ADDR), SYNC_STAGES (2..4).
// -----------------------------------------------------------------------------
module async_fifo_rd_ctrl
   import async_fifo_rd_ctrl_pkg::*;
#(
   parameter int W_ADDR      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   async_fifo_rd_ctrl_if.slave  bus
);

   localparam int PTR_W = cdc_ptr_width(W_ADDR);

   logic [PTR_W-1:0] wptr_gray_sync;
   logic [PTR_W-1:0] wptr_bin;
   logic [PTR_W-1:0] rptr_bin;
   logic [PTR_W-1:0] rptr_bin_next;
   logic [PTR_W-1:0] rptr_gray_q;
   logic             empty_c;
   logic             pop_c;

   cdc_sync_bus #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.wptr_gray_async),
      .q   (wptr_gray_sync)
   );

   // NOTE: every signal is assigned on every pass through this block, so no
   // latch can be inferred.
   always_comb begin
      wptr_bin      = PTR_W'(cdc_gray2bin(CDC_MAX_W'(wptr_gray_sync)));
      // Gray-to-Gray compare uses registered values only, so empty is clean.
      empty_c       = (rptr_gray_q == wptr_gray_sync);
      // No pop may be issued during a reset cycle, even if the registers
      // still show entries from before the reset.
      pop_c         = bus.ren & ~empty_c & ~rst;
      rptr_bin_next = rptr_bin + PTR_W'(pop_c);
   end

   // rptr_gray is registered from the next binary value, so it leaves the
   // domain as a flop output that changes at most one bit per edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_bin    <= '0;
         rptr_gray_q <= '0;
      end else begin
         rptr_bin    <= rptr_bin_next;
         rptr_gray_q <= PTR_W'(cdc_bin2gray(CDC_MAX_W'(rptr_bin_next)));
      end
   end

   assign bus.rptr_gray     = rptr_gray_q;
   assign bus.mem_raddr     = rptr_bin[W_ADDR-1:0];
   assign bus.empty         = empty_c;
   // Modulo subtraction keeps level correct across the pointer wrap; values
   // above the depth come from a misbehaving writer and are passed through.
   assign bus.level         = wptr_bin - rptr_bin;
   assign bus.pop           = pop_c;
   assign bus.err_underflow = bus.ren & (empty_c | rst);

endmodule
